// File: rtl/xor_trigger_pkg.sv
// Shared definitions for the xor_trigger edge-to-pulse block: edge-mode
// encodings, stretch counter width and the per-lane edge qualifier.
package xor_trigger_pkg;

  typedef enum logic [1:0] {
    EDGE_BOTH = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_mode_e;

  localparam int CNT_W = 8;

  // s1 is the newest sample, s2 the one before it.
  function automatic logic raw_edge(edge_mode_e mode, logic s1, logic s2);
    case (mode)
      EDGE_RISE: return s1 & ~s2;
      EDGE_FALL: return ~s1 & s2;
      default:   return s1 ^ s2;
    endcase
  endfunction

endpackage

// File: rtl/xor_trigger_if.sv
// Level-input / pulse-output bundle of xor_trigger. No handshake: in is an
// asynchronous level, out is a registered pulse, both sampled every cycle.
interface xor_trigger_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;

  modport master (output in, input out);
  modport slave  (input in, output out);
endinterface

// File: rtl/xor_trigger_lane.sv
// One bit lane: capture/history flops, edge qualifier and a reloadable
// stretch counter that keeps the registered pulse high STRETCH cycles.
module xor_trigger_lane
  import xor_trigger_pkg::*;
#(
  parameter edge_mode_e EDGE_MODE = EDGE_BOTH,
  parameter int         STRETCH   = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic prime_i,
  input  logic in_i,
  output logic out_o
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STRETCH);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             raw;

  always_comb begin
    s1_d  = in_i;
    // Until primed, history follows the input so a static level is no edge.
    s2_d  = prime_i ? s1_q : in_i;
    raw   = raw_edge(EDGE_MODE, s1_q, s2_q);
    cnt_d = cnt_q;
    if (raw) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    out_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/xor_trigger.sv
// Multi-lane synchronous edge trigger. rstn is active-high despite its name;
// the first clock after release primes every lane's history.
module xor_trigger
  import xor_trigger_pkg::*;
#(
  parameter int         WIDTH     = 1,
  parameter edge_mode_e EDGE_MODE = EDGE_BOTH,
  parameter int         STRETCH   = 1
) (
  input  logic         clk,
  input  logic         rstn,
  xor_trigger_if.slave bus
);

  if (WIDTH < 1) begin : g_bad_width
    $error("xor_trigger: WIDTH must be at least 1");
  end
  if (STRETCH < 1 || STRETCH > 255) begin : g_bad_stretch
    $error("xor_trigger: STRETCH must be within 1..255");
  end

  logic             prime_q;
  logic [WIDTH-1:0] in_w;
  logic [WIDTH-1:0] out_w;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      prime_q <= 1'b0;
    end else begin
      prime_q <= 1'b1;
    end
  end

  assign in_w = bus.in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    xor_trigger_lane #(
      .EDGE_MODE (EDGE_MODE),
      .STRETCH   (STRETCH)
    ) u_lane (
      .clk_i   (clk),
      .rst_i   (rstn),
      .prime_i (prime_q),
      .in_i    (in_w[i]),
      .out_o   (out_w[i])
    );
  end

  assign bus.out = out_w;

endmodule

// File: tb/tb_xor_trigger.sv
// Four xor_trigger configurations driven in lockstep from one directed table;
// a monitor pops expected {a,b,c[3:0],d} outputs one cycle at a time.
module tb_xor_trigger;
  import xor_trigger_pkg::*;

  logic clk = 1'b0;
  logic rst;

  xor_trigger_if #(.WIDTH(1)) bus_a ();
  xor_trigger_if #(.WIDTH(1)) bus_b ();
  xor_trigger_if #(.WIDTH(4)) bus_c ();
  xor_trigger_if #(.WIDTH(1)) bus_d ();

  xor_trigger #(.WIDTH(1), .EDGE_MODE(EDGE_BOTH), .STRETCH(1)) u_a (
    .clk (clk), .rstn (rst), .bus (bus_a.slave));
  xor_trigger #(.WIDTH(1), .EDGE_MODE(EDGE_RISE), .STRETCH(3)) u_b (
    .clk (clk), .rstn (rst), .bus (bus_b.slave));
  xor_trigger #(.WIDTH(4), .EDGE_MODE(EDGE_BOTH), .STRETCH(1)) u_c (
    .clk (clk), .rstn (rst), .bus (bus_c.slave));
  xor_trigger #(.WIDTH(1), .EDGE_MODE(EDGE_FALL), .STRETCH(2)) u_d (
    .clk (clk), .rstn (rst), .bus (bus_d.slave));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [6:0] exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         mon_idx     = 0;
  logic [6:0] got;

  assign got = {bus_a.out, bus_b.out, bus_c.out, bus_d.out};

  function automatic logic [6:0] mk(logic a, logic b, logic [3:0] c, logic d);
    return {a, b, c, d};
  endfunction

  task automatic compare(input string name, input int idx,
                         input logic [6:0] act, input logic [6:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s #%0d: {a,b,c,d} got %b expected %b at %0t",
               name, idx, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_x(input logic x);
    bus_a.in = x;
    bus_b.in = x;
    bus_d.in = x;
  endtask

  // Inputs change mid-cycle; exp is the output after the following rising edge.
  task automatic drive(input logic x, input logic [3:0] c, input logic r,
                       input logic glitch, input logic [6:0] exp);
    @(negedge clk);
    rst = r;
    if (glitch) begin
      set_x(~x);
      #2;
    end
    set_x(x);
    bus_c.in = c;
    exp_q.push_back(exp);
  endtask

  task automatic reset_now(input logic [6:0] pre);
    @(negedge clk);
    compare("pre_reset", 0, got, pre);
    rst = 1'b1;
    #1;
    compare("async_reset", 0, got, 7'b0);
    exp_q.push_back(7'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        compare("scoreboard", mon_idx, got, e);
        mon_idx++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    set_x(1'b0);
    bus_c.in = 4'b0000;
    #1;
    compare("reset_state", 0, got, 7'b0);

    drive(1'b0, 4'b0000, 1'b1, 1'b0, 7'b0);
    drive(1'b0, 4'b0000, 1'b1, 1'b0, 7'b0);

    // release; first edge primes, out(n) reflects in at n-1 vs n-2
    drive(1'b0, 4'b0000, 1'b0, 1'b0, mk(0, 0, 4'b0000, 0)); // n0
    drive(1'b0, 4'b0000, 1'b0, 1'b0, mk(0, 0, 4'b0000, 0)); // n1
    drive(1'b1, 4'b0101, 1'b0, 1'b0, mk(0, 0, 4'b0000, 0)); // n2
    drive(1'b1, 4'b0101, 1'b0, 1'b0, mk(1, 1, 4'b0101, 0)); // n3 rise
    drive(1'b0, 4'b0101, 1'b0, 1'b0, mk(0, 1, 4'b0000, 0)); // n4
    drive(1'b0, 4'b0101, 1'b0, 1'b0, mk(1, 1, 4'b0000, 1)); // n5 fall
    drive(1'b0, 4'b1111, 1'b0, 1'b0, mk(0, 0, 4'b0000, 1)); // n6
    drive(1'b1, 4'b1111, 1'b0, 1'b0, mk(0, 0, 4'b1010, 0)); // n7
    drive(1'b0, 4'b0000, 1'b0, 1'b0, mk(1, 1, 4'b0000, 0)); // n8 rise
    drive(1'b1, 4'b0000, 1'b0, 1'b0, mk(1, 1, 4'b1111, 1)); // n9 fall
    drive(1'b0, 4'b0000, 1'b0, 1'b0, mk(1, 1, 4'b0000, 1)); // n10 rise, B reload
    drive(1'b0, 4'b0000, 1'b0, 1'b0, mk(1, 1, 4'b0000, 1)); // n11 fall, D reload
    drive(1'b0, 4'b0000, 1'b0, 1'b1, mk(0, 1, 4'b0000, 1)); // n12 glitch
    drive(1'b0, 4'b0000, 1'b0, 1'b0, mk(0, 0, 4'b0000, 0)); // n13
    drive(1'b0, 4'b0000, 1'b0, 1'b0, mk(0, 0, 4'b0000, 0)); // n14
    drive(1'b0, 4'b0000, 1'b0, 1'b0, mk(0, 0, 4'b0000, 0)); // n15
    drive(1'b1, 4'b0000, 1'b0, 1'b0, mk(0, 0, 4'b0000, 0)); // n16
    drive(1'b1, 4'b0000, 1'b0, 1'b0, mk(1, 1, 4'b0000, 0)); // n17 rise

    // reset in the middle of B's three-cycle pulse, in held at 1
    reset_now(mk(1, 1, 4'b0000, 0));
    drive(1'b1, 4'b0000, 1'b1, 1'b0, 7'b0);
    drive(1'b1, 4'b0000, 1'b1, 1'b0, 7'b0);

    // release with static in=1: priming must suppress any pulse
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 7'b0);                 // n0'
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 7'b0);                 // n1'
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 7'b0);                 // n2'
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 7'b0);                 // n3'
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 7'b0);                 // n4'
    drive(1'b0, 4'b0000, 1'b0, 1'b0, mk(1, 0, 4'b0000, 1)); // n5' fall
    drive(1'b0, 4'b0000, 1'b0, 1'b0, mk(0, 0, 4'b0000, 1)); // n6'
    drive(1'b0, 4'b0000, 1'b0, 1'b0, mk(0, 0, 4'b0000, 0)); // n7'
    drive(1'b0, 4'b0000, 1'b0, 1'b0, mk(0, 0, 4'b0000, 0)); // n8'

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xor_trigger.md
XOR_TRIGGER -- requirements
Module: xor_trigger

Interface
REQ-001 Parameter WIDTH, default 1, number of independent input/output bit lanes.
REQ-002 Parameter EDGE_MODE, default EDGE_BOTH, selects trigger edge: EDGE_BOTH, EDGE_RISE or EDGE_FALL.
REQ-003 Parameter STRETCH, default 1, output pulse length in clk cycles; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rstn  input  1  asynchronous, active-high reset (asserted when rstn=1), despite the historical port name.
REQ-006 in  input  WIDTH  level input, asynchronous to clk, may change at any time.
REQ-007 out  output  WIDTH  registered trigger pulse, one bit per lane.

Function
REQ-008 Each lane SHALL hold a capture register s1 (s1<=in) and a history register s2 (s2<=s1), both updated every clk rising edge.
REQ-009 Raw edge SHALL be s1^s2 for EDGE_BOTH, s1&~s2 for EDGE_RISE, ~s1&s2 for EDGE_FALL.
REQ-010 Edge detection SHALL be fully synchronous; out SHALL never depend combinationally on in.
REQ-011 Latency: a change of in sampled at rising edge k SHALL set out=1 from rising edge k+1.
REQ-012 out SHALL remain 1 for exactly STRETCH cycles after the last qualifying edge, then return to 0.
REQ-013 A qualifying edge while out is already high SHALL reload the per-lane stretch counter to STRETCH, extending the pulse; no gap SHALL appear.
REQ-014 With STRETCH=1, in toggling every cycle SHALL hold out continuously at 1.
REQ-015 Input changes that go and return between two rising edges (glitches) SHALL NOT produce a pulse.
REQ-016 Lanes SHALL be fully independent; activity on one lane SHALL NOT affect another.
REQ-017 The first rising edge after reset release SHALL load both s1 and s2 with in (priming), so a static in=1 at release produces no pulse.
REQ-018 Qualifying edges SHALL be detected from the second rising edge after reset release onward.

Reset
REQ-019 While rstn=1, s1, s2, stretch counters, prime flag and out SHALL be 0, asynchronously and immediately.
REQ-020 Reset asserted mid-pulse SHALL force out=0 at once; no pending pulse SHALL survive reset.
REQ-021 Reset deassertion SHALL be taken at a rising clk edge; the next rising edge is the priming edge (REQ-017).

Structure
REQ-022 Package xor_trigger_pkg SHALL hold the EDGE_BOTH/EDGE_RISE/EDGE_FALL encodings (2-bit enum) and the stretch-counter width constant (8).
REQ-023 One sub-module xor_trigger_lane (s1, s2, edge select, stretch counter, out register for one bit) SHALL be instantiated WIDTH times via generate.
REQ-024 The top level SHALL contain only parameter checks, the shared prime flag and the lane generate loop.

Verification
REQ-025 WIDTH=1, BOTH, STRETCH=1: reset, release with in=0, raise in mid-cycle before edge k -> out=1 only during cycle k+1..k+2, 0 otherwise.
REQ-026 Same config, drop in back to 0 two cycles later -> second one-cycle pulse, 1 cycle after sampling; out=0 between pulses.
REQ-027 EDGE_RISE, STRETCH=3: rising in -> out high 3 cycles; falling in -> out stays 0; retrigger at cycle 2 of pulse -> pulse extends to 3 cycles from retrigger.
REQ-028 Hold in=1 through reset release -> out stays 0 (priming); later in 1->0 with BOTH -> one pulse.
REQ-029 Assert rstn=1 while out=1 -> out=0 within same timestep, no pulse after release with static in.
REQ-030 WIDTH=4, in 4'b0000 -> 4'b0101 -> out 4'b0101 for one cycle, lanes 1 and 3 remain 0.
